if_prefetch_queue: RTL and testbench

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

---
 rtl/if_prefetch_queue.sv | 166 ++++++++++++++++
 tb/tb_if_prefetch_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: AHB-Lite instruction prefetcher feeding a DEPTH-entry
// circular queue.
//
// Address phases issue back-to-back while there is room for the word and for
// the outstanding data phase. A redirect flushes the queue and marks any data
// phase still on the bus as drop.
//
// Optional feature: define IF_PREFETCH_FAULT_EN to add the out_fault output.
// With it, each entry records i_hresp, and a faulting word stops fetch until
// the next redirect.
module if_prefetch_queue #(
   parameter int                  PC_WIDTH = 32,
   parameter int                  DEPTH    = 4,
   parameter logic [PC_WIDTH-1:0] RST_ADDR = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   input  logic                d_itcm,
   output logic [PC_WIDTH-1:0] i_haddr,
   output logic [1:0]          i_htrans,
   output logic [2:0]          i_hsize,
   output logic [2:0]          i_hburst,
   output logic [3:0]          i_hprot,
   output logic                i_hsel,
   input  logic                i_hready,
   input  logic                i_hresp,
   input  logic [31:0]         i_hrdata,
`ifdef IF_PREFETCH_FAULT_EN
   output logic                out_fault,
`endif
   output logic                out_valid,
   output logic [31:0]         out_instr,
   output logic [PC_WIDTH-1:0] out_pc,
   input  logic                out_ready
);

   localparam int              AW      = $clog2(DEPTH);
   localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, WAIT_ITCM} state_t;

   state_t              state;
   logic [PC_WIDTH-1:0] fetch_pc;
   logic [PC_WIDTH-1:0] data_pc;
   logic                inflight;
   logic                drop;
   logic [AW-1:0]       rd_ptr;
   logic [AW-1:0]       wr_ptr;
   logic [AW:0]         count;
   logic [AW:0]         occupancy;
   logic [31:0]         instr_mem [DEPTH];
   logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
   logic                halt;
   logic                issue;
   logic                complete;
   logic                push;
   logic                pop;

   // The outstanding data phase reserves a slot, so the queue never overflows.
   assign occupancy = count + {{AW{1'b0}}, inflight};
   assign issue     = (state == RUN) & i_hready & ~d_itcm & ~redirect_valid & ~halt
                      & (occupancy < DEPTH_C);
   assign complete  = inflight & i_hready;
   assign push      = complete & ~drop & ~redirect_valid;
   assign pop       = out_valid & out_ready & ~redirect_valid;

   assign i_haddr   = fetch_pc;
   assign i_htrans  = issue ? 2'b10 : 2'b00;
   assign i_hsize   = 3'b010;
   assign i_hburst  = 3'b000;
   assign i_hprot   = 4'b0011;
   assign i_hsel    = ~d_itcm;
   assign out_valid = (count != '0);
   assign out_instr = instr_mem[rd_ptr];
   assign out_pc    = pc_mem[rd_ptr];

   // Control FSM: a single idle cycle after reset, then follow the ITCM arbitration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         case (state)
            BOOT:      state <= RUN;
            RUN:       if (d_itcm) state <= WAIT_ITCM;
            WAIT_ITCM: if (!d_itcm) state <= RUN;
            default:   state <= BOOT;
         endcase
      end
   end

   // Fetch address and bookkeeping for the single outstanding data phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RST_ADDR;
         data_pc  <= '0;
         inflight <= 1'b0;
         drop     <= 1'b0;
      end else begin
         if (redirect_valid)  fetch_pc <= redirect_pc;
         else if (issue)      fetch_pc <= fetch_pc + PC_WIDTH'(4);
         if (issue) begin
            inflight <= 1'b1;
            data_pc  <= fetch_pc;
            drop     <= 1'b0;
         end else if (complete) begin
            inflight <= 1'b0;
            drop     <= 1'b0;
         end
         // A phase still waiting when the redirect lands returns stale data.
         if (redirect_valid && inflight && !i_hready) drop <= 1'b1;
      end
   end

   // Circular queue storage and pointers; a redirect empties it outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
         end
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            instr_mem[wr_ptr] <= i_hrdata;
            pc_mem[wr_ptr]    <= data_pc;
            wr_ptr            <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
      end
   end

`ifdef IF_PREFETCH_FAULT_EN
   logic [DEPTH-1:0] fault_mem;

   // Per-entry bus error flag; the first faulting word halts fetch until a redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt      <= 1'b0;
         fault_mem <= '0;
      end else if (redirect_valid) begin
         halt <= 1'b0;
      end else if (push) begin
         fault_mem[wr_ptr] <= i_hresp;
         if (i_hresp) halt <= 1'b1;
      end
   end

   assign out_fault = out_valid & fault_mem[rd_ptr];
`else
   logic unused_hresp;

   assign halt         = 1'b0;
   assign unused_hresp = i_hresp;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed bench for if_prefetch_queue.
// A queue-based transaction model checks the bus and queue outputs every
// cycle. Literal checks pin the latency, capacity, redirect, wait-state and
// ITCM scenarios. Define IF_PREFETCH_FAULT_EN to also exercise the
// bus-error path.
module tb_if_prefetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RST   = 32'h0;
`ifdef IF_PREFETCH_FAULT_EN
   localparam bit          FLT   = 1'b1;
`else
   localparam bit          FLT   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        d_itcm = 1'b0;
   logic [31:0] i_haddr;
   logic [1:0]  i_htrans;
   logic [2:0]  i_hsize;
   logic [2:0]  i_hburst;
   logic [3:0]  i_hprot;
   logic        i_hsel;
   logic        i_hready = 1'b1;
   logic        i_hresp;
   logic [31:0] i_hrdata;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready = 1'b1;
   logic        out_fault;
   logic        flt_en = 1'b0;
   logic [31:0] s_addr;

   int total = 0;
   int bad = 0;

   if_prefetch_queue #(.PC_WIDTH(32), .DEPTH(DEPTH), .RST_ADDR(RST)) dut (
      .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .d_itcm(d_itcm), .i_haddr(i_haddr), .i_htrans(i_htrans), .i_hsize(i_hsize),
      .i_hburst(i_hburst), .i_hprot(i_hprot), .i_hsel(i_hsel), .i_hready(i_hready),
      .i_hresp(i_hresp), .i_hrdata(i_hrdata),
`ifdef IF_PREFETCH_FAULT_EN
      .out_fault(out_fault),
`endif
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
   );

`ifndef IF_PREFETCH_FAULT_EN
   assign out_fault = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Memory slave: returns the word of the last accepted address; 0x8 errors when enabled.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) s_addr <= '0;
      else if (i_htrans == 2'b10 && i_hready) s_addr <= i_haddr;
   assign i_hrdata = word_at(s_addr);
   assign i_hresp  = flt_en && (s_addr == 32'h8);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model state
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        flt;
   } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_dpc;
   bit          m_boot, m_wait, m_inf, m_drop, m_halt, e_issue;
   int          cyc;
   int          first_v;
   int          ns_cnt;
   logic [31:0] addr_log[$];
   int          cyc_log[$];

   // Compare process: expected outputs from the model, then advance the model one cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_boot = 1; m_wait = 0; m_inf = 0; m_drop = 0; m_halt = 0;
         m_pc = RST; m_dpc = '0; m_q.delete(); cyc = 0;
         chk("rst_htrans", 64'(i_htrans), 64'(0));
         chk("rst_valid", 64'(out_valid), 64'(0));
         chk("rst_instr", 64'(out_instr), 64'(0));
         chk("rst_pc", 64'(out_pc), 64'(0));
         chk("rst_fault", 64'(out_fault), 64'(0));
      end else begin
         e_issue = !m_boot && !m_wait && i_hready && !d_itcm && !redirect_valid && !m_halt
                   && (m_q.size() + int'(m_inf) < DEPTH);
         chk("htrans", 64'(i_htrans), e_issue ? 64'(2) : 64'(0));
         if (e_issue) chk("haddr", 64'(i_haddr), 64'(m_pc));
         chk("hsel", 64'(i_hsel), 64'(!d_itcm));
         chk("hconst", 64'({i_hsize, i_hburst, i_hprot}), 64'({3'b010, 3'b000, 4'b0011}));
         chk("valid", 64'(out_valid), 64'(m_q.size() != 0));
         if (m_q.size() != 0) begin
            chk("out_pc", 64'(out_pc), 64'(m_q[0].pc));
            chk("out_instr", 64'(out_instr), 64'(m_q[0].instr));
         end
         chk("out_fault", 64'(out_fault), 64'(m_q.size() != 0 && m_q[0].flt));
         if (i_htrans == 2'b10) begin
            addr_log.push_back(i_haddr);
            cyc_log.push_back(cyc);
            ns_cnt++;
         end
         if (out_valid && first_v < 0) first_v = cyc;
         if (redirect_valid) begin
            m_q.delete();
            m_pc   = redirect_pc;
            m_halt = 0;
            m_drop = m_inf && !i_hready;
            m_inf  = m_inf && !i_hready;
         end else begin
            if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
            if (m_inf && i_hready) begin
               if (!m_drop) begin
                  m_q.push_back('{pc: m_dpc, instr: word_at(m_dpc), flt: FLT && i_hresp});
                  if (FLT && i_hresp) m_halt = 1;
               end
               m_inf = 0; m_drop = 0;
            end
            if (e_issue) begin
               m_inf = 1; m_dpc = m_pc; m_pc += 32'd4; m_drop = 0;
            end
         end
         m_wait = !m_boot && d_itcm;
         m_boot = 0;
         cyc++;
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves the bench at the start of the BOOT cycle (cycle 0).
   task automatic do_reset(input logic ordy);
      rst_n = 0; redirect_valid = 0; d_itcm = 0; i_hready = 1; out_ready = ordy;
      @(posedge clk); @(posedge clk); #1;
      addr_log.delete(); cyc_log.delete(); ns_cnt = 0; first_v = -1;
      rst_n = 1;
   endtask

   initial begin
      logic [31:0] a;

      // Back-to-back fetch from reset and the first-valid latency
      do_reset(1'b1);
      step(8);
      chk("a_addr0", 64'(addr_log[0]), 64'h0);
      chk("a_addr1", 64'(addr_log[1]), 64'h4);
      chk("a_addr2", 64'(addr_log[2]), 64'h8);
      chk("a_cyc0", 64'(cyc_log[0]), 64'd1);
      chk("a_cyc2", 64'(cyc_log[2]), 64'd3);
      chk("a_first_valid", 64'(first_v), 64'd3);

      // Decode stalled: exactly DEPTH address phases, one more after a pop
      do_reset(1'b0);
      step(10);
      chk("b_nonseq", 64'(ns_cnt), 64'd4);
      chk("b_head_pc", 64'(out_pc), 64'h0);
      chk("b_head_instr", 64'(out_instr), 64'h1357_6420);
      out_ready = 1;
      step();
      out_ready = 0;
      step(6);
      chk("b_nonseq_pop", 64'(ns_cnt), 64'd5);
      chk("b_addr4", 64'(addr_log[4]), 64'h10);

      // Redirect with a waiting data phase drops the stale word
      do_reset(1'b0);
      step();
      step();
      redirect_valid = 1; redirect_pc = 32'h100; i_hready = 0;
      step();
      redirect_valid = 0; i_hready = 1;
      step();
      #1 chk("c_flushed", 64'(out_valid), 64'd0);
      step(2);
      chk("c_head_valid", 64'(out_valid), 64'd1);
      chk("c_head_pc", 64'(out_pc), 64'h100);
      chk("c_head_instr", 64'(out_instr), 64'h1257_6520);
      chk("c_addr1", 64'(addr_log[1]), 64'h100);
      // Redirect coinciding with data-phase completion
      redirect_valid = 1; redirect_pc = 32'h200;
      step();
      redirect_valid = 0;
      step(3);
      chk("c_coincide_pc", 64'(out_pc), 64'h200);

      // Three wait states: address held, a single push
      do_reset(1'b0);
      step();
      step();
      i_hready = 0;
      for (int k = 0; k < 3; k++) begin
         #1 a = i_haddr;
         chk("d_haddr_hold", 64'(a), 64'h4);
         step();
      end
      i_hready = 1;
      step();
      i_hready = 0;
      chk("d_valid", 64'(out_valid), 64'd1);
      chk("d_pc", 64'(out_pc), 64'h0);
      chk("d_instr", 64'(out_instr), 64'h1357_6420);
      out_ready = 1;
      step();
      out_ready = 0;
      #1 chk("d_single_push", 64'(out_valid), 64'd0);
      chk("d_nonseq", 64'(ns_cnt), 64'd2);
      i_hready = 1;
      step(3);

      // ITCM steal for two cycles
      do_reset(1'b1);
      step(3);
      d_itcm = 1;
      #1 chk("e_hsel0", 64'(i_hsel), 64'd0);
      chk("e_idle0", 64'(i_htrans), 64'd0);
      step();
      #1 chk("e_hsel1", 64'(i_hsel), 64'd0);
      chk("e_idle1", 64'(i_htrans), 64'd0);
      step();
      d_itcm = 0;
      step(4);
      chk("e_resume_addr", 64'(addr_log[2]), 64'h8);
      chk("e_resume_cyc", 64'(cyc_log[2]), 64'd6);

      // Mixed traffic; model checks every cycle
      do_reset(1'b1);
      for (int i = 0; i < 60; i++) begin
         step();
         i_hready       = (i % 5) != 2;
         out_ready      = (i % 7) < 4;
         d_itcm         = (i % 11) == 5;
         redirect_valid = (i % 17) == 9;
         redirect_pc    = 32'h400 + 32'(i) * 32'd16;
      end
      // Reset in the middle of a transfer restarts at RST_ADDR
      do_reset(1'b1);
      step(3);
      chk("f_restart_addr", 64'(addr_log[0]), 64'(RST));

`ifdef IF_PREFETCH_FAULT_EN
      // Bus error on 0x8 halts fetch until a redirect
      flt_en = 1;
      do_reset(1'b0);
      step(8);
      chk("g_nonseq", 64'(ns_cnt), 64'd4);
      out_ready = 1;
      step(2);
      out_ready = 0;
      #1 chk("g_head_pc", 64'(out_pc), 64'h8);
      chk("g_head_fault", 64'(out_fault), 64'd1);
      step(3);
      chk("g_halted", 64'(ns_cnt), 64'd4);
      redirect_valid = 1; redirect_pc = 32'h100; flt_en = 0;
      step();
      redirect_valid = 0;
      step(4);
      chk("g_clear_pc", 64'(out_pc), 64'h100);
      chk("g_clear_fault", 64'(out_fault), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
